// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared JPEG front-end types and constants
package jpeg_pkg;

    localparam int JPEG_BLK_LEN = 64;

    typedef enum logic [1:0] {
        COMP_Y  = 2'd0,
        COMP_CB = 2'd1,
        COMP_CR = 2'd2
    } comp_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority selector
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [IW-1:0] idx
);

    localparam logic [IW:0] NV = (IW+1)'(N);

    logic [IW:0] cand;

    // Scan from last+1 upward (mod N); the first set request wins.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, last} + (IW+1)'(k);
            if (cand >= NV) begin
                cand = cand - NV;
            end
            if (!any && req[cand[IW-1:0]]) begin
                any = 1'b1;
                idx = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/jpeg_block_arbiter.sv
// rtl/jpeg_block_arbiter.sv - round-robin whole-block scheduler for the shared DCT datapath
module jpeg_block_arbiter
    import jpeg_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int DW      = 8,
    parameter int BLK_LEN = JPEG_BLK_LEN,
    parameter int CW      = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              dp_valid,
    output logic [DW-1:0]     dp_data,
    output logic [CW-1:0]     dp_comp,
    output logic              dp_first,
    output logic              dp_last,
    input  logic              dp_ready,
    output logic              busy,
    output logic              blk_done,
    output logic [15:0]       blk_cnt
);

    localparam int              CNTW     = $clog2(BLK_LEN);
    localparam logic [CW-1:0]   LAST_RST = CW'(NREQ - 1);
    localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(BLK_LEN - 1);

    arb_state_t      state_q, state_d;
    logic [CW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   last_q, last_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            blk_done_q, blk_done_d;
    logic [15:0]     blk_cnt_q, blk_cnt_d;

    logic            pick_any;
    logic [CW-1:0]   pick_idx;
    logic            hs;

    rr_pick #(
        .N  (NREQ),
        .IW (CW)
    ) u_pick (
        .req  (req_valid),
        .last (last_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Zero-latency pass-through of the granted source plus block-position tags.
    always_comb begin
        busy      = (state_q == BURST);
        dp_valid  = busy && req_valid[grant_q];
        dp_data   = req_data[int'(grant_q)*DW +: DW];
        req_ready = '0;
        if (busy) begin
            req_ready[grant_q] = dp_ready;
        end
        dp_first  = dp_valid && (cnt_q == '0);
        dp_last   = dp_valid && (cnt_q == CNT_MAX);
        hs        = dp_valid && dp_ready;
        dp_comp   = grant_q;
        blk_done  = blk_done_q;
        blk_cnt   = blk_cnt_q;
    end

    // Next-state: arbitrate in IDLE, hold the grant for one whole block in BURST.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        blk_done_d = 1'b0;
        blk_cnt_d  = blk_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (hs) begin
                    if (cnt_q == CNT_MAX) begin
                        last_d     = grant_q;
                        cnt_d      = '0;
                        blk_done_d = 1'b1;
                        blk_cnt_d  = blk_cnt_q + 16'd1;
                        state_d    = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any partial block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_q     <= LAST_RST;
            cnt_q      <= '0;
            blk_done_q <= 1'b0;
            blk_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            blk_done_q <= blk_done_d;
            blk_cnt_q  <= blk_cnt_d;
        end
    end

endmodule

// File: tb/tb_jpeg_block_arbiter.sv
// tb/tb_jpeg_block_arbiter.sv - randomized self-checking bench for jpeg_block_arbiter
module tb_jpeg_block_arbiter;

    localparam int N   = 3;
    localparam int DW  = 8;
    localparam int BLK = 64;
    localparam int CW  = 2;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data  = '0;
    logic            dp_ready  = 1'b0;
    logic [N-1:0]    req_ready;
    logic            dp_valid;
    logic [DW-1:0]   dp_data;
    logic [CW-1:0]   dp_comp;
    logic            dp_first;
    logic            dp_last;
    logic            busy;
    logic            blk_done;
    logic [15:0]     blk_cnt;

    jpeg_block_arbiter #(.NREQ(N), .DW(DW), .BLK_LEN(BLK), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .dp_valid(dp_valid), .dp_data(dp_data),
        .dp_comp(dp_comp), .dp_first(dp_first), .dp_last(dp_last),
        .dp_ready(dp_ready), .busy(busy), .blk_done(blk_done), .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Source model: pending samples per source and a copy of everything sent.
    logic [7:0]   srcq [N][$];
    logic [7:0]   sent [N][$];
    logic [N-1:0] en = '0;
    bit           rand_rdy = 0;

    // Reference model of the scheduling rules.
    bit          m_busy   = 0;
    int          m_grant  = 0;
    int          m_last   = N - 1;
    int          m_cnt    = 0;
    logic [15:0] m_blkcnt = '0;
    bit          exp_done = 0;
    int          cyc      = 0;

    // Observations from the most recent cycle.
    bit         hs_seen;
    int         hs_comp;
    bit         hs_first;
    bit         hs_last;
    logic [7:0] hs_data;
    bit         done_seen;

    function automatic int rr_ref(logic [N-1:0] v, int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic fill(int src, int n);
        logic [7:0] b;
        for (int k = 0; k < n; k++) begin
            b = 8'($urandom_range(0, 255));
            srcq[src].push_back(b);
            sent[src].push_back(b);
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            sent[i].delete();
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_grant = 0; m_last = N - 1; m_cnt = 0; m_blkcnt = '0; exp_done = 0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; en = '0; req_valid = '0; dp_ready = 1'b0;
        clear_sources();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive sources, compare DUT with the model, advance the model.
    task automatic cycle();
        logic [N-1:0] v;
        logic [N-1:0] exp_rdy;
        int g;
        bit hs;
        for (int i = 0; i < N; i++) begin
            v[i] = en[i] && (srcq[i].size() > 0);
            req_data[i*DW +: DW] = (srcq[i].size() > 0) ? srcq[i][0] : 8'h00;
        end
        req_valid = v;
        dp_ready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        checks++;
        if (blk_done !== exp_done) begin
            errors++; $display("FAIL blk_done cyc=%0d: got %b expected %b", cyc, blk_done, exp_done);
        end
        checks++;
        if (blk_cnt !== m_blkcnt) begin
            errors++; $display("FAIL blk_cnt cyc=%0d: got %0h expected %0h", cyc, blk_cnt, m_blkcnt);
        end
        checks++;
        if (dp_comp !== CW'(m_grant)) begin
            errors++; $display("FAIL dp_comp cyc=%0d: got %0d expected %0d", cyc, dp_comp, m_grant);
        end
        checks++;
        if ($countones(req_ready) > 1) begin
            errors++; $display("FAIL ready_onehot cyc=%0d: got %b expected at most one bit", cyc, req_ready);
        end
        exp_rdy = '0;
        g  = -1;
        hs = 0;
        if (!m_busy) begin
            checks++;
            if (busy !== 1'b0 || req_ready !== '0 || dp_valid !== 1'b0 || dp_first !== 1'b0 || dp_last !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs cyc=%0d: got busy=%b rdy=%b v=%b f=%b l=%b expected all zero",
                         cyc, busy, req_ready, dp_valid, dp_first, dp_last);
            end
            g = rr_ref(v, m_last);
        end else begin
            exp_rdy[m_grant] = dp_ready;
            checks++;
            if (busy !== 1'b1) begin
                errors++; $display("FAIL busy cyc=%0d: got %b expected 1", cyc, busy);
            end
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++; $display("FAIL req_ready cyc=%0d: got %b expected %b", cyc, req_ready, exp_rdy);
            end
            checks++;
            if (dp_valid !== v[m_grant]) begin
                errors++; $display("FAIL dp_valid cyc=%0d: got %b expected %b", cyc, dp_valid, v[m_grant]);
            end
            if (v[m_grant]) begin
                checks++;
                if (dp_data !== srcq[m_grant][0]) begin
                    errors++; $display("FAIL dp_data cyc=%0d: got %0h expected %0h", cyc, dp_data, srcq[m_grant][0]);
                end
                checks++;
                if (dp_first !== (m_cnt == 0) || dp_last !== (m_cnt == BLK - 1)) begin
                    errors++;
                    $display("FAIL first_last cyc=%0d sample=%0d: got f=%b l=%b expected f=%b l=%b",
                             cyc, m_cnt, dp_first, dp_last, (m_cnt == 0), (m_cnt == BLK - 1));
                end
            end
            hs = v[m_grant] && dp_ready;
        end
        hs_seen   = hs;
        hs_comp   = int'(dp_comp);
        hs_first  = dp_first;
        hs_last   = dp_last;
        hs_data   = dp_data;
        done_seen = blk_done;
        @(posedge clk);
        exp_done = 0;
        if (!m_busy) begin
            if (g >= 0) begin
                m_busy = 1; m_grant = g; m_cnt = 0;
            end
        end else if (hs) begin
            void'(srcq[m_grant].pop_front());
            m_cnt++;
            if (m_cnt == BLK) begin
                m_busy = 0; m_last = m_grant; m_cnt = 0; exp_done = 1; m_blkcnt++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '1; dp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_ready !== '0 || dp_valid !== 1'b0 || dp_first !== 1'b0 ||
            dp_last !== 1'b0 || dp_comp !== '0 || blk_done !== 1'b0 || blk_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_values: got busy=%b rdy=%b v=%b f=%b l=%b comp=%0d done=%b cnt=%0h expected all zero",
                     busy, req_ready, dp_valid, dp_first, dp_last, dp_comp, blk_done, blk_cnt);
        end
        reset_dut();
        repeat (3) cycle();
    endtask

    task automatic test_rotation();
        int firsts[$];
        int starts[$];
        int start;
        logic [15:0] target;
        start  = (m_last + 1) % N;
        target = m_blkcnt + 16'd4;
        rand_rdy = 0;
        for (int i = 0; i < N; i++) fill(i, 2 * BLK);
        en = '1;
        for (int t = 0; t < 400 && m_blkcnt != target; t++) begin
            cycle();
            if (hs_seen && hs_first) begin
                firsts.push_back(hs_comp);
                starts.push_back(cyc);
            end
        end
        en = '0;
        cycle();
        checks++;
        if (m_blkcnt != target || firsts.size() != 4) begin
            errors++; $display("FAIL rotation_blocks: got %0d block starts expected 4", firsts.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (firsts[k] != (start + k) % N) begin
                    errors++; $display("FAIL rotation_grant[%0d]: got %0d expected %0d", k, firsts[k], (start + k) % N);
                end
            end
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (starts[k] - starts[k-1] != BLK + 1) begin
                    errors++; $display("FAIL burst_spacing[%0d]: got %0d expected %0d", k, starts[k] - starts[k-1], BLK + 1);
                end
            end
        end
        checks++;
        if (blk_cnt !== target) begin
            errors++; $display("FAIL rotation_blk_cnt: got %0d expected %0d", blk_cnt, target);
        end
        clear_sources();
    endtask

    task automatic test_single_source();
        int nhs = 0;
        int dones = 0;
        int first_at = -1;
        int last_at = -1;
        reset_dut();
        fill(2, BLK);
        en = 3'b100;
        cycle();
        checks++;
        if (busy !== 1'b1 || dp_comp !== 2'd2) begin
            errors++; $display("FAIL single_grant_cycle2: got busy=%b comp=%0d expected busy=1 comp=2", busy, dp_comp);
        end
        for (int t = 0; t < 100 && m_blkcnt != 16'd1; t++) begin
            cycle();
            if (hs_seen) begin
                nhs++;
                if (hs_first) first_at = nhs;
                if (hs_last) last_at = nhs;
            end
        end
        repeat (3) begin
            cycle();
            if (done_seen) dones++;
        end
        checks++;
        if (first_at != 1 || last_at != BLK) begin
            errors++; $display("FAIL single_flags: got first@%0d last@%0d expected first@1 last@%0d", first_at, last_at, BLK);
        end
        checks++;
        if (dones != 1) begin
            errors++; $display("FAIL single_done_pulses: got %0d expected 1", dones);
        end
        en = '0;
    endtask

    task automatic test_stall();
        int hs1 = 0;
        int stall_hs = 0;
        int firsts[$];
        logic [15:0] base;
        base = m_blkcnt;
        fill(1, BLK);
        fill(0, BLK);
        en = 3'b010;
        cycle();
        en = 3'b011;
        for (int t = 0; t < 100 && !(m_busy && m_grant == 1 && m_cnt == 30); t++) begin
            cycle();
            if (hs_seen && hs_comp == 1) hs1++;
            if (hs_seen && hs_first) firsts.push_back(hs_comp);
        end
        en[1] = 1'b0;
        repeat (10) begin
            cycle();
            if (hs_seen) stall_hs++;
        end
        checks++;
        if (stall_hs != 0 || dp_comp !== 2'd1 || hs1 != 30) begin
            errors++; $display("FAIL stall_hold: got hs=%0d comp=%0d before=%0d expected hs=0 comp=1 before=30",
                               stall_hs, dp_comp, hs1);
        end
        en[1] = 1'b1;
        for (int t = 0; t < 100 && m_blkcnt != base + 16'd1; t++) begin
            cycle();
            if (hs_seen && hs_comp == 1) hs1++;
            if (hs_seen && hs_first) firsts.push_back(hs_comp);
        end
        checks++;
        if (hs1 != BLK) begin
            errors++; $display("FAIL stall_block_len: got %0d expected %0d", hs1, BLK);
        end
        for (int t = 0; t < 100 && m_blkcnt != base + 16'd2; t++) begin
            cycle();
            if (hs_seen && hs_first) firsts.push_back(hs_comp);
        end
        checks++;
        if (firsts.size() != 2 || firsts[0] != 1 || firsts[1] != 0) begin
            errors++; $display("FAIL stall_grant_order: got %0d starts expected grants 1 then 0", firsts.size());
        end
        en = '0;
        cycle();
    endtask

    task automatic test_random_ready();
        logic [7:0] rx [N][$];
        int bad;
        logic [15:0] target;
        clear_sources();
        target = m_blkcnt + 16'd3;
        for (int i = 0; i < N; i++) fill(i, BLK);
        en = '1;
        rand_rdy = 1;
        for (int t = 0; t < 2000 && m_blkcnt != target; t++) begin
            cycle();
            if (hs_seen) rx[hs_comp].push_back(hs_data);
        end
        rand_rdy = 0;
        en = '0;
        cycle();
        checks++;
        if (m_blkcnt != target) begin
            errors++; $display("FAIL random_timeout: got %0d blocks expected 3", m_blkcnt - (target - 16'd3));
        end
        for (int i = 0; i < N; i++) begin
            bad = 0;
            if (rx[i].size() != sent[i].size()) bad = 1;
            else for (int k = 0; k < rx[i].size(); k++) if (rx[i][k] !== sent[i][k]) bad++;
            checks++;
            if (bad != 0 || rx[i].size() != BLK) begin
                errors++; $display("FAIL random_stream[%0d]: got %0d samples (%0d bad) expected %0d in order",
                                   i, rx[i].size(), bad, BLK);
            end
        end
        clear_sources();
    endtask

    task automatic test_reset_mid_block();
        int first_comp = -1;
        bit first_flag = 0;
        for (int i = 0; i < N; i++) fill(i, BLK);
        en = '1;
        for (int t = 0; t < 200 && !(m_busy && m_cnt == 40); t++) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || req_ready !== '0 || dp_valid !== 1'b0 || dp_first !== 1'b0 ||
            dp_last !== 1'b0 || dp_comp !== '0 || blk_done !== 1'b0 || blk_cnt !== 16'h0) begin
            errors++;
            $display("FAIL midblock_reset: got busy=%b rdy=%b v=%b comp=%0d done=%b cnt=%0h expected all zero",
                     busy, req_ready, dp_valid, dp_comp, blk_done, blk_cnt);
        end
        en = '0;
        clear_sources();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) fill(i, BLK);
        en = '1;
        for (int t = 0; t < 10 && first_comp < 0; t++) begin
            cycle();
            if (hs_seen) begin
                first_comp = hs_comp;
                first_flag = hs_first;
            end
        end
        checks++;
        if (first_comp != 0 || !first_flag) begin
            errors++; $display("FAIL post_reset_grant: got comp=%0d first=%b expected comp=0 first=1", first_comp, first_flag);
        end
        for (int t = 0; t < 400 && m_blkcnt != 16'd3; t++) cycle();
        en = '0;
        cycle();
        clear_sources();
    endtask

    task automatic test_wrap();
        int dones = 0;
        en = '0;
        cycle();
        force dut.blk_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.blk_cnt_q;
        @(negedge clk);
        m_blkcnt = 16'hFFFF;
        checks++;
        if (blk_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_preload: got %0h expected ffff", blk_cnt);
        end
        fill(1, BLK);
        en = 3'b010;
        for (int t = 0; t < 100 && m_blkcnt != 16'h0; t++) begin
            cycle();
            if (done_seen) dones++;
        end
        cycle();
        if (done_seen) dones++;
        checks++;
        if (blk_cnt !== 16'h0 || dones != 1) begin
            errors++; $display("FAIL wrap: got cnt=%0h dones=%0d expected cnt=0 dones=1", blk_cnt, dones);
        end
        en = '0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_single_source();
        test_stall();
        test_random_ready();
        test_reset_mid_block();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
